// File: rtl/dac_ramp_pkg.sv
// Shared types and constants for the DAC setpoint ramp sequencer.
package dac_ramp_pkg;

    localparam int unsigned DW_DEFAULT         = 20;
    localparam int unsigned DEPTH_LOG2_DEFAULT = 14;

    localparam logic [1:0] OPMODE_SMOOTH = 2'd0;
    localparam logic [1:0] OPMODE_JUMP   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RD   = 3'd2,
        ST_OUT  = 3'd3,
        ST_WAIT = 3'd4
    } ramp_state_e;

endpackage : dac_ramp_pkg

// File: rtl/dac_ramp_ram.sv
// Ramp table storage: simple dual-port RAM, one write port, registered read.
module dac_ramp_ram #(
    parameter int unsigned DEPTH_LOG2 = 14,
    parameter int unsigned DW         = 20
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DW-1:0]         wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DW-1:0]         rdata_o
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read port, one cycle of latency; left unreset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : dac_ramp_ram

// File: rtl/dac_ramp_ctrl.sv
// Setpoint sequencer for one DAC channel: jump mode forwards register writes,
// smooth mode plays the ramp table one sample per tick.
// Optional macro DAC_RAMP_OVERRUN_CNT_EN builds the dropped-tick counter.
module dac_ramp_ctrl
    import dac_ramp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int unsigned DW         = DW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            opmode,
    input  logic [DW-1:0]         setpt,
    input  logic                  setpt_wr,
    input  logic [DEPTH_LOG2:0]   ramp_len,
    input  logic [DEPTH_LOG2-1:0] ramp_addr,
    input  logic [DW-1:0]         ramp_data,
    input  logic                  ramp_we,
    input  logic                  ramp_run,
    input  logic                  tick,
    output logic [DW-1:0]         dac_data,
    output logic                  dac_valid,
    input  logic                  dac_ready,
    output logic                  ramp_active,
    output logic                  ramp_done,
    output logic [DEPTH_LOG2:0]   ramp_idx,
    output logic [15:0]           overrun_cnt
);
    localparam int unsigned   LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] DEPTH = LW'(2 ** DEPTH_LOG2);

    ramp_state_e   state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic          done_q, done_d;
    logic          active_q, active_d;

    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          tab_we;

    // Table writes are only taken while no ramp is playing
    assign tab_we = ramp_we && (state_q == ST_IDLE);

    dac_ramp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DW         (DW)
    ) u_ram (
        .clk     (clk),
        .we_i    (tab_we),
        .waddr_i (ramp_addr),
        .wdata_i (ramp_data),
        .re_i    (rd_en),
        .raddr_i (idx_q[DEPTH_LOG2-1:0]),
        .rdata_o (rd_data)
    );

    // Next-state, output handshake and playback sequencing
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        len_d   = len_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;

        if (valid_q && dac_ready) begin
            valid_d = 1'b0;
        end

        if (opmode == OPMODE_SMOOTH) begin
            case (state_q)
                ST_IDLE: begin
                    if (ramp_run) begin
                        if (ramp_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            len_d   = (ramp_len > DEPTH) ? DEPTH : ramp_len;
                            idx_d   = '0;
                            state_d = ST_ARM;
                        end
                    end
                end
                ST_ARM, ST_WAIT: begin
                    if (tick) begin
                        rd_en   = 1'b1;
                        state_d = ST_RD;
                    end
                end
                ST_RD: begin
                    data_d  = rd_data;
                    valid_d = 1'b1;
                    idx_d   = idx_q + LW'(1);
                    state_d = ST_OUT;
                end
                ST_OUT: begin
                    if (valid_q && dac_ready) begin
                        if (idx_q == len_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            // Leaving smooth mode aborts playback; a pending sample still drains
            state_d = ST_IDLE;
            if ((opmode == OPMODE_JUMP) && setpt_wr) begin
                data_d  = setpt;
                valid_d = 1'b1;
            end
        end

        active_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

    assign dac_data    = data_q;
    assign dac_valid   = valid_q;
    assign ramp_idx    = idx_q;
    assign ramp_done   = done_q;
    assign ramp_active = active_q;

`ifdef DAC_RAMP_OVERRUN_CNT_EN
    logic        overrun_tick;
    logic        run_start;
    logic [15:0] ovr_q, ovr_d;

    // A tick landing while a sample is still in flight is dropped
    assign overrun_tick = (opmode == OPMODE_SMOOTH) && tick &&
                          ((state_q == ST_RD) || (state_q == ST_OUT));
    assign run_start    = (opmode == OPMODE_SMOOTH) && ramp_run && (state_q == ST_IDLE);

    // Saturating dropped-tick counter, cleared when a ramp is started
    always_comb begin
        ovr_d = ovr_q;
        if (run_start) begin
            ovr_d = '0;
        end else if (overrun_tick && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_cnt = ovr_q;
`else
    assign overrun_cnt = 16'h0000;
`endif

endmodule : dac_ramp_ctrl
